// File: rtl/ring_inject_arbiter.sv
// ring_inject_arbiter
//   Merges ring through-traffic and local PE injections onto one downstream
//   link through a single output register (EMPTY/FULL). Ring traffic has
//   priority. Accepted ring flits get their hop count [55:48] decremented,
//   saturating at zero, and a sticky error flag records any hop-0 arrival.
//
//   Optional feature macro: RING_ARB_AGING_EN
//     When defined, a 3-bit starvation counter tracks ring wins while the PE
//     is waiting. Once it reaches STARVE_LIMIT, the PE wins the next load
//     opportunity. When undefined, strict ring priority applies and
//     STARVE_LIMIT only has its range checked.
//
//   Handshake: a transfer happens on a port when valid and ready are both
//   high at a rising clk edge. Readies may depend combinationally on valids.
//   Valids must never depend on readies. At most one of ring_ri/pe_ri is
//   high in any cycle, and both are low while reset is high.
//
//   The EMPTY/FULL state is visible on link_so, which is 1 exactly when the
//   state is FULL.
module ring_inject_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ring_si,
  output logic        ring_ri,
  input  logic [63:0] ring_di,
  input  logic        pe_si,
  output logic        pe_ri,
  input  logic [63:0] pe_di,
  output logic        link_so,
  input  logic        link_ro,
  output logic [63:0] link_do,
  output logic        err_hop0
);

  // Reject an out-of-range starvation limit at elaboration time.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
    $error("ring_inject_arbiter: STARVE_LIMIT must be in 1..7");
  end

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e      r_state;
  logic [63:0] r_data;
  logic        r_err_hop0;

  logic        w_drain;
  logic        w_can_load;
  logic        w_pe_first;
  logic        w_grant_ring;
  logic        w_grant_pe;
  logic        w_ring_load;
  logic        w_pe_load;
  logic        w_load;
  logic [7:0]  w_ring_hop;
  logic        w_hop_zero;
  logic [63:0] w_ring_flit;

  // The register drains when it is full and the link accepts. It can take
  // a new flit when it is empty or draining, and never while reset is high.
  assign w_drain    = (r_state == ST_FULL) && link_ro;
  assign w_can_load = !reset && ((r_state == ST_EMPTY) || w_drain);

`ifdef RING_ARB_AGING_EN
  localparam logic [2:0] LP_STARVE_LIMIT = 3'(STARVE_LIMIT);

  logic [2:0] r_starve_cnt;

  assign w_pe_first = (r_starve_cnt == LP_STARVE_LIMIT);

  // Count ring wins over a waiting PE, saturate at the limit, and clear
  // when the PE finally loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 3'd0;
    end else if (w_pe_load) begin
      r_starve_cnt <= 3'd0;
    end else if (w_ring_load && pe_si && (r_starve_cnt != LP_STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 3'd1;
    end
  end
`else
  assign w_pe_first = 1'b0;
`endif

  // Pick at most one requester. The ring wins unless aging has promoted
  // a waiting PE.
  always_comb begin
    w_grant_ring = 1'b0;
    w_grant_pe   = 1'b0;
    if (w_pe_first && pe_si) begin
      w_grant_pe = 1'b1;
    end else if (ring_si) begin
      w_grant_ring = 1'b1;
    end else if (pe_si) begin
      w_grant_pe = 1'b1;
    end
  end

  assign ring_ri     = w_grant_ring && w_can_load;
  assign pe_ri       = w_grant_pe && w_can_load;
  assign w_ring_load = ring_si && ring_ri;
  assign w_pe_load   = pe_si && pe_ri;
  assign w_load      = w_ring_load || w_pe_load;

  // Ring flits lose one hop. A hop count that is already zero stays zero.
  assign w_ring_hop  = ring_di[55:48];
  assign w_hop_zero  = (w_ring_hop == 8'd0);
  assign w_ring_flit = {ring_di[63:56],
                        (w_hop_zero ? 8'd0 : (w_ring_hop - 8'd1)),
                        ring_di[47:0]};

  // Output register FSM. A load wins over a drain, so a simultaneous load
  // and drain stays FULL with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_data  <= 64'd0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_load) begin
            r_state <= ST_FULL;
            r_data  <= w_ring_load ? w_ring_flit : pe_di;
          end
        end
        ST_FULL: begin
          if (w_load) begin
            r_state <= ST_FULL;
            r_data  <= w_ring_load ? w_ring_flit : pe_di;
          end else if (w_drain) begin
            r_state <= ST_EMPTY;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

  // Sticky flag for a ring flit accepted with hop count zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_hop0 <= 1'b0;
    end else if (w_ring_load && w_hop_zero) begin
      r_err_hop0 <= 1'b1;
    end
  end

  assign link_so  = (r_state == ST_FULL);
  assign link_do  = r_data;
  assign err_hop0 = r_err_hop0;

endmodule

// File: tb/tb_ring_inject_arbiter.sv
// tb_ring_inject_arbiter
//   Directed, table-driven bench for ring_inject_arbiter, plus hand-written
//   sequences for reset, mid-operation reset and sustained contention.
//   Inputs change 1 time unit after each rising edge. Readies are sampled
//   1 unit after that, and registered outputs 1 unit after the next edge.
module tb_ring_inject_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        ring_si;
  logic        ring_ri;
  logic [63:0] ring_di;
  logic        pe_si;
  logic        pe_ri;
  logic [63:0] pe_di;
  logic        link_so;
  logic        link_ro;
  logic [63:0] link_do;
  logic        err_hop0;

  int n_checks;
  int n_errors;

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ring_inject_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .ring_si  (ring_si),
    .ring_ri  (ring_ri),
    .ring_di  (ring_di),
    .pe_si    (pe_si),
    .pe_ri    (pe_ri),
    .pe_di    (pe_di),
    .link_so  (link_so),
    .link_ro  (link_ro),
    .link_do  (link_do),
    .err_hop0 (err_hop0)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        ring_si;
    logic [63:0] ring_di;
    logic        pe_si;
    logic [63:0] pe_di;
    logic        link_ro;
    logic        exp_ring_ri;
    logic        exp_pe_ri;
    logic        exp_so;
    logic [63:0] exp_do;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r_si, input logic [63:0] r_di, input logic p_si,
                       input logic [63:0] p_di, input logic l_ro);
    ring_si = r_si;
    ring_di = r_di;
    pe_si   = p_si;
    pe_di   = p_di;
    link_ro = l_ro;
  endtask

  // Hold reset for two cycles with every valid high, then check the
  // cleared state.
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    drive(1'b1, 64'h4005_0000_dead_beef, 1'b1, 64'h0001_0000_cafe_f00d, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("%s ring_ri in reset c%0d", tag, c), {63'd0, ring_ri}, 64'd0);
      check($sformatf("%s pe_ri in reset c%0d", tag, c), {63'd0, pe_ri}, 64'd0);
      @(posedge clk);
      #1;
    end
    check({tag, " link_so"}, {63'd0, link_so}, 64'd0);
    check({tag, " link_do"}, link_do, 64'd0);
    check({tag, " err_hop0"}, {63'd0, err_hop0}, 64'd0);
    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
  endtask

  // Expected outputs of the contention run, one entry per cycle.
  logic [63:0] exp_q[$];
  logic        exp_pe_q[$];

  initial begin
    int ring_cnt;
    int pe_cnt;
    int pe_seen;
    logic [63:0] exp_word;
    logic        exp_pe;

    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    drive(1'b0, 64'd0, 1'b0, 64'd0, 1'b0);

    // Fields: ring_si, ring_di, pe_si, pe_di, link_ro,
    //         exp_ring_ri, exp_pe_ri, exp_so, exp_do, exp_err
    // PE only: the flit passes unmodified.
    vecs[0]  = '{1'b0, 64'd0, 1'b1, 64'h0003_0002_3333_4444, 1'b1,
                 1'b0, 1'b1, 1'b1, 64'h0003_0002_3333_4444, 1'b0};
    // Ring flit: hop 02 -> 01. Drain and load in the same cycle.
    vecs[1]  = '{1'b1, 64'h4002_0004_7777_8888, 1'b0, 64'd0, 1'b1,
                 1'b1, 1'b0, 1'b1, 64'h4001_0004_7777_8888, 1'b0};
    // Ring flit with hop 0: forwarded with hop 0, error set.
    vecs[2]  = '{1'b1, 64'h0000_0001_0000_0000, 1'b0, 64'd0, 1'b1,
                 1'b1, 1'b0, 1'b1, 64'h0000_0001_0000_0000, 1'b1};
    // Idle drain: register empties, data held, error stays sticky.
    vecs[3]  = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b1,
                 1'b0, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b1};
    // Both valid while empty: ring wins. Link then stalls.
    vecs[4]  = '{1'b1, 64'h4005_1111_2222_3333, 1'b1, 64'h0009_0000_aaaa_bbbb, 1'b0,
                 1'b1, 1'b0, 1'b1, 64'h4004_1111_2222_3333, 1'b1};
    // Backpressure for five cycles: no readies, output held.
    vecs[5]  = '{1'b1, 64'h40ff_0000_0000_0001, 1'b1, 64'h0009_0000_aaaa_bbbb, 1'b0,
                 1'b0, 1'b0, 1'b1, 64'h4004_1111_2222_3333, 1'b1};
    vecs[6]  = vecs[5];
    vecs[7]  = vecs[5];
    vecs[8]  = vecs[5];
    vecs[9]  = vecs[5];
    // Link frees up with a ring flit waiting: drain and reload, so stays high.
    vecs[10] = '{1'b1, 64'h4003_5555_6666_7777, 1'b0, 64'd0, 1'b1,
                 1'b1, 1'b0, 1'b1, 64'h4002_5555_6666_7777, 1'b1};
    // PE flit while full and draining.
    vecs[11] = '{1'b0, 64'd0, 1'b1, 64'h00ab_0000_1234_5678, 1'b1,
                 1'b0, 1'b1, 1'b1, 64'h00ab_0000_1234_5678, 1'b1};
    // Idle drain back to empty.
    vecs[12] = '{1'b0, 64'd0, 1'b0, 64'd0, 1'b1,
                 1'b0, 1'b0, 1'b0, 64'h00ab_0000_1234_5678, 1'b1};

    next_cycle();
    apply_reset("initial reset");

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].ring_si, vecs[i].ring_di, vecs[i].pe_si, vecs[i].pe_di, vecs[i].link_ro);
      #1;
      check($sformatf("vec%0d ring_ri", i), {63'd0, ring_ri}, {63'd0, vecs[i].exp_ring_ri});
      check($sformatf("vec%0d pe_ri", i), {63'd0, pe_ri}, {63'd0, vecs[i].exp_pe_ri});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d link_so", i), {63'd0, link_so}, {63'd0, vecs[i].exp_so});
      check($sformatf("vec%0d link_do", i), link_do, vecs[i].exp_do);
      check($sformatf("vec%0d err_hop0", i), {63'd0, err_hop0}, {63'd0, vecs[i].exp_err});
    end

    // ---------------- mid-operation reset ----------------
    // Load a flit into a stalled link, then reset: the flit must be lost.
    drive(1'b1, 64'h4010_0000_0bad_0bad, 1'b0, 64'd0, 1'b0);
    next_cycle();
    check("stalled load link_so", {63'd0, link_so}, 64'd1);
    check("stalled load link_do", link_do, 64'h400f_0000_0bad_0bad);
    apply_reset("mid-op reset");

    // ---------------- sustained contention ----------------
    // Build the expected per-cycle winners and words.
    for (int i = 0; i < 20; i++) begin
`ifdef RING_ARB_AGING_EN
      exp_pe = ((i % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
`else
      exp_pe = 1'b0;
`endif
      exp_pe_q.push_back(exp_pe);
      exp_q.push_back(exp_pe ? (64'h0001_0022_0000_0000 | 64'(i))
                             : (64'h400f_0000_0000_0000 | 64'(i)));
    end
    ring_cnt = 0;
    pe_cnt   = 0;
    pe_seen  = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 64'h4010_0000_0000_0000 | 64'(i), 1'b1,
            64'h0001_0022_0000_0000 | 64'(i), 1'b1);
      #1;
      exp_pe   = exp_pe_q.pop_front();
      exp_word = exp_q.pop_front();
      if (ring_ri) ring_cnt++;
      if (pe_ri) begin
        pe_cnt++;
        pe_seen = 1;
      end
      check($sformatf("contend%0d ring_ri", i), {63'd0, ring_ri}, {63'd0, !exp_pe});
      check($sformatf("contend%0d pe_ri", i), {63'd0, pe_ri}, {63'd0, exp_pe});
      @(posedge clk);
      #1;
      check($sformatf("contend%0d link_so", i), {63'd0, link_so}, 64'd1);
      check($sformatf("contend%0d link_do", i), link_do, exp_word);
    end
`ifdef RING_ARB_AGING_EN
    check("contention ring flits", 64'(ring_cnt), 64'd16);
    check("contention pe flits", 64'(pe_cnt), 64'd4);
`else
    check("contention ring flits", 64'(ring_cnt), 64'd20);
    check("contention pe_ri ever high", 64'(pe_seen), 64'd0);
`endif

    // Final drain back to empty.
    drive(1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
    next_cycle();
    check("final drain link_so", {63'd0, link_so}, 64'd0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ring_inject_arbiter.md
RING_INJECT_ARBITER -- requirements
Module: ring_inject_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost PE arbitrations before PE is forced; legal range 1..7.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ring_si  input  1  through-traffic flit valid from the upstream ring stage.
REQ-005 SHALL have port ring_ri  output  1  through-traffic ready.
REQ-006 SHALL have port ring_di  input  64  through-traffic flit: [62] direction, [55:48] hop count.
REQ-007 SHALL have port pe_si  input  1  local PE injection valid.
REQ-008 SHALL have port pe_ri  output  1  local PE injection ready.
REQ-009 SHALL have port pe_di  input  64  local PE flit, same field layout.
REQ-010 SHALL have port link_so  output  1  downstream link valid.
REQ-011 SHALL have port link_ro  input  1  downstream link ready.
REQ-012 SHALL have port link_do  output  64  downstream link flit.
REQ-013 SHALL have port err_hop0  output  1  sticky flag: a ring flit arrived with hop count 0.

Function
REQ-014 SHALL hold one output register (state EMPTY/FULL); link_so = FULL, link_do = register contents.
REQ-015 SHALL treat a transfer on any port as valid & ready high at a rising edge.
REQ-016 SHALL compute can_load = EMPTY or (link_so & link_ro); drain and load in the same cycle give zero bubble.
REQ-017 SHALL grant at most one requester per cycle; ring_ri and pe_ri SHALL never be high together.
REQ-018 SHALL assert the ready of the granted requester only, equal to can_load; ready depends on valids combinationally; valids must not depend on ready.
REQ-019 SHALL by default give ring priority: ring_si wins; PE granted only when ring_si=0.
REQ-020 SHALL load a ring flit with [55:48] decremented by 1 and all other bits unchanged; flit latency 1 cycle from accept to link_so.
REQ-021 SHALL saturate a ring hop count of 0 at 0 (flit still forwarded) and set err_hop0, which stays set until reset.
REQ-022 SHALL load a PE flit unmodified (hop count not decremented).
REQ-023 SHALL hold link_do and link_so stable while link_so=1 and link_ro=0; both readies SHALL be 0 in that case.
REQ-024 SHALL transition EMPTY->FULL on load without drain, FULL->EMPTY on drain without load, and stay FULL on simultaneous drain and load.

Reset
REQ-025 SHALL on reset=1 at a rising edge force EMPTY, link_so=0, link_do=0, err_hop0=0, starvation counter=0.
REQ-026 SHALL discard any held flit when reset is asserted mid-operation; no transfer completes in a cycle where reset=1.
REQ-027 SHALL drive ring_ri=0 and pe_ri=0 while reset=1.

Configuration
REQ-028 SHALL compile aging logic only when macro RING_ARB_AGING_EN is defined.
REQ-029 With RING_ARB_AGING_EN: 3-bit starve_cnt increments on each ring load while pe_si=1; saturates at STARVE_LIMIT; clears on PE load.
REQ-030 With RING_ARB_AGING_EN: when starve_cnt == STARVE_LIMIT, PE wins over ring on the next load opportunity.
REQ-031 Without RING_ARB_AGING_EN: strict ring priority; no counter present; STARVE_LIMIT ignored; PE may starve indefinitely.

Verification
REQ-032 Reset: hold reset=1 two cycles with all valids=1 -> link_so=0, link_do=0, err_hop0=0, ring_ri=pe_ri=0.
REQ-033 PE only: pe_di=64'h0003_0002_3333_4444, pe_si=1 one cycle, link_ro=1 -> next cycle link_so=1, link_do=64'h0003_0002_3333_4444.
REQ-034 Ring only: ring_di=64'h4002_0004_7777_8888 -> link_do=64'h4001_0004_7777_8888 one cycle later; ring_di=64'h0000_0001_0000_0000 -> link_do hop field 00, err_hop0=1 and stays 1.
REQ-035 Backpressure: load a flit with link_ro=0 for 5 cycles -> link_do stable, ring_ri=pe_ri=0; link_ro=1 with ring_si=1 -> drain and reload same cycle, link_so stays 1.
REQ-036 Contention without macro: ring_si=pe_si=1 continuously for 20 cycles, link_ro=1 -> 20 ring flits, pe_ri never 1.
REQ-037 Contention with RING_ARB_AGING_EN, STARVE_LIMIT=4: same stimulus -> repeating pattern of 4 ring flits then 1 PE flit.
